usb_uart_tx: RTL and testbench
==============================

Name: usb_uart_tx

Overview:
Serial transmitter stage directly downstream of the USB-to-UART bridge endpoint. Consumes the bridge's host-OUT byte pipeline (`uart_out_data`/`uart_out_valid`/`uart_out_ready`) and serializes each byte onto a UART TX line as 8N1, LSB first. A one-byte holding register decouples the pipeline handshake from the bit shifter, so consecutive bytes go out back-to-back with no idle gap.

Parameters:
- CLKS_PER_BIT, 417, clk cycles per UART bit (48 MHz / 115200). Legal range 2..65535.
- CNT_W, 16, width of the baud counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- uart_out_data  input  8  byte from the bridge pipeline.
- uart_out_valid  input  1  uart_out_data is valid.
- uart_out_ready  output  1  block accepts the byte this cycle.
- uart_tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line or the holding register is full.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, uart_tx=1, hold_valid=0, uart_out_ready=1, busy=0.
  - Baud counter and bit counter = 0.
  - Reset asserted mid-frame forces uart_tx high immediately. The partial frame and any held byte are discarded.
- Handshake:
  - uart_out_ready = ~hold_valid (registered flag; no combinational path from valid to ready).
  - A transfer occurs on a clock edge where uart_out_valid && uart_out_ready. The byte is written to the hold register and hold_valid is set.
  - While uart_out_ready=0, data and valid are ignored. The upstream holds them.
- Shifter load:
  - Occurs when hold_valid=1 and either state=IDLE, or state=STOP on the last cycle of the stop bit.
  - On load: shift register <= hold data, hold_valid <= 0, state <= START, baud counter <= 0.
  - Load and accept never coincide, because ready is low while hold_valid=1.
- Latency: a byte accepted at edge N is loaded at edge N+1. uart_tx falls after edge N+1, so two edges from handshake to start bit.
- State machine: IDLE -> START -> DATA -> STOP -> (IDLE | START).
  - IDLE: uart_tx=1. Stays here until hold_valid=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit end. The 3-bit bit counter advances 0..7; after bit 7 go to STOP (or PARITY when enabled).
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, go to START if hold_valid=1, else IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1. Terminal count ends the bit and the counter wraps to 0. The counter never free-runs in IDLE.
  - Frame length = 10*CLKS_PER_BIT cycles (11 with parity).
- uart_tx is driven from a register (glitch-free).
- busy = (state != IDLE) || hold_valid.

Optional Feature:
- Macro: USB_UART_TX_PARITY_EN.
- When defined:
  - Add a PARITY state between DATA and STOP.
  - uart_tx = even parity (XOR of the 8 data bits, computed at load) for CLKS_PER_BIT cycles.
  - Frame = 11 bit times.
- When undefined: no PARITY state or parity logic; frame = 10 bit times (8N1).

Test Plan (bench uses CLKS_PER_BIT=4, parity off unless noted):
1. Reset release, no valid -> uart_tx=1, uart_out_ready=1, busy=0 held for 100 cycles.
2. Single byte 0x55, one-cycle valid -> ready drops 1 cycle after accept then returns. uart_tx samples every 4 cycles starting 2 edges after accept read 0,1,0,1,0,1,0,1,0,1. busy falls exactly 40 cycles after the start bit began.
3. Bytes 0xA3, 0x0F with valid held continuously -> second byte accepted during the first frame. Stop bit of 0xA3 is followed immediately by the start bit of 0x0F: 80 contiguous frame cycles, no idle high gap beyond stop.
4. Valid held with 3 bytes -> uart_out_ready low whenever hold is full. No byte is lost or duplicated; decoded line = 3 bytes in order.
5. Reset asserted mid-DATA of 0xFF -> uart_tx=1 asynchronously. After release, hold empty, ready=1, no residual frame emitted.
6. With USB_UART_TX_PARITY_EN, bytes 0x07 and 0x03 -> parity bit 1 for 0x07 and 0 for 0x03, each frame 44 cycles.

Source files
------------

// File: rtl/usb_uart_tx_if.sv
// Host-OUT byte pipeline between the USB bridge endpoint and the UART transmitter.
interface usb_uart_tx_if;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;

  modport master (output uart_out_data, output uart_out_valid, input uart_out_ready);
  modport slave  (input uart_out_data, input uart_out_valid, output uart_out_ready);
endinterface

// File: rtl/usb_uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
// Define USB_UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11 bit times per frame).
module usb_uart_tx #(
  parameter int CLKS_PER_BIT = 417,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          reset,
  usb_uart_tx_if.slave  s_if,
  output logic          uart_tx,
  output logic          busy
);

`ifdef USB_UART_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_PARITY} state_t;
  localparam state_t S_STOP_SEL = S_PARITY;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_hold;
  logic             r_hold_valid;
  logic             r_tx, w_tx_nxt;
  logic             w_bit_end;
  logic             w_load;
`ifdef USB_UART_TX_PARITY_EN
  logic             r_par;
  logic             r_in_stop;
`endif

  assign w_bit_end          = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign s_if.uart_out_ready = ~r_hold_valid;
  assign uart_tx            = r_tx;
`ifdef USB_UART_TX_PARITY_EN
  assign busy = (r_state != S_IDLE) || r_in_stop || r_hold_valid;
`else
  assign busy = (r_state != S_IDLE) || r_hold_valid;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_tx_nxt    = 1'b1;
    if (r_state != S_IDLE
`ifdef USB_UART_TX_PARITY_EN
        || r_in_stop
`endif
       ) w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
`ifdef USB_UART_TX_PARITY_EN
    // Four states fill the 2-bit encoding, so STOP is S_IDLE qualified by r_in_stop.
    if (r_in_stop) begin
      if (w_bit_end) w_load = r_hold_valid;
    end else begin
`endif
    case (r_state)
      S_IDLE:  w_load = r_hold_valid;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA: if (w_bit_end) begin
        w_shift_nxt = {1'b0, r_shift[7:1]};
        w_bit_nxt   = r_bit + 3'd1;
`ifdef USB_UART_TX_PARITY_EN
        if (r_bit == 3'd7) w_state_nxt = S_PARITY;
`else
        if (r_bit == 3'd7) w_state_nxt = S_STOP;
`endif
      end
`ifdef USB_UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_nxt = S_IDLE;
`else
      S_STOP: if (w_bit_end) begin
        if (r_hold_valid) w_load = 1'b1;
        else              w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef USB_UART_TX_PARITY_EN
    end
`endif
    if (w_load) begin
      w_state_nxt = S_START;
      w_shift_nxt = r_hold;
      w_cnt_nxt   = '0;
      w_bit_nxt   = 3'd0;
    end
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef USB_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'h00;
      r_hold       <= 8'h00;
      r_hold_valid <= 1'b0;
      r_tx         <= 1'b1;
`ifdef USB_UART_TX_PARITY_EN
      r_par        <= 1'b0;
      r_in_stop    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef USB_UART_TX_PARITY_EN
      if (w_load) r_par <= ^r_hold;
      if (w_load)                                      r_in_stop <= 1'b0;
      else if (r_state == S_PARITY && w_bit_end)       r_in_stop <= 1'b1;
      else if (r_in_stop && w_bit_end)                 r_in_stop <= 1'b0;
`endif
      // Load and accept are mutually exclusive: ready is low whenever the hold is full.
      if (w_load) begin
        r_hold_valid <= 1'b0;
      end else if (s_if.uart_out_valid && !r_hold_valid) begin
        r_hold       <= s_if.uart_out_data;
        r_hold_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_uart_tx.sv
// Random-stimulus bench: a line decoder reconstructs frames and is scored against accepted bytes.
module tb_usb_uart_tx;
  localparam int CPB = 4;
`ifdef USB_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_tx, busy;
  usb_uart_tx_if bus();

  usb_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .s_if(bus), .uart_tx(uart_tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       rx_p[$];
  int         rx_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line decoder: samples mid-bit after each falling edge seen while idle.
  initial begin
    logic [7:0] d;
    logic p;
    int t0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_tx == 1'b0) begin
        t0 = cyc;
        p  = 1'b0;
        repeat (2) @(negedge clk);
        if (uart_tx == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = uart_tx;
          end
`ifdef USB_UART_TX_PARITY_EN
          repeat (CPB) @(negedge clk);
          p = uart_tx;
`endif
          repeat (CPB) @(negedge clk);
          chk("stop_bit", int'(uart_tx), 1);
          rx_q.push_back(d);
          rx_p.push_back(p);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    bus.uart_out_data  = b;
    bus.uart_out_valid = 1'b1;
    while (!bus.uart_out_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_wait_bound", int'(t < 200), 1);
    @(posedge clk);
    exp_q.push_back(b);
    #1;
    chk("rdy_low_after_accept", int'(bus.uart_out_ready), 0);
  endtask

  task automatic drop();
    @(negedge clk);
    bus.uart_out_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_bound", int'(t < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_q(input string tag);
    logic [7:0] e, r;
    logic p;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      p = rx_p.pop_front();
      chk(tag, int'(r), int'(e));
`ifdef USB_UART_TX_PARITY_EN
      chk({tag, "_par"}, int'(p), int'(^e));
`else
      chk({tag, "_par_none"}, int'(p), 0);
`endif
    end
    exp_q.delete(); rx_q.delete(); rx_p.delete(); rx_t.delete();
  endtask

  initial begin
    logic [7:0] b;
    int lows;
    bus.uart_out_data  = 8'h00;
    bus.uart_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        chk("rst_tx", int'(uart_tx), 1);
        chk("rst_ready", int'(bus.uart_out_ready), 1);
        chk("rst_busy", int'(busy), 0);
      end
    end

    // 2: single 0x55, exact waveform and busy timing
    send(8'h55);
    drop();
    @(negedge clk);
    chk("t2_rdy_back", int'(bus.uart_out_ready), 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) repeat (CPB) @(negedge clk);
      chk($sformatf("t2_tx%0d", k), int'(uart_tx), k % 2);
    end
    repeat (3) @(negedge clk);
    chk("t2_busy_end_m1", int'(busy), 1);
    @(negedge clk);
    chk("t2_busy_end", int'(busy), 0);
    wait_idle();
    cmp_q("t2_byte");

    // 3: back-to-back 0xA3, 0x0F
    send(8'hA3);
    send(8'h0F);
    drop();
    wait_idle();
    if (rx_t.size() == 2) chk("t3_gap", rx_t[1] - rx_t[0], NB * CPB);
    else chk("t3_frames", rx_t.size(), 2);
    cmp_q("t3_byte");

    // 4: three bytes with valid held
    send(8'h3C);
    send(8'hE1);
    send(8'h96);
    drop();
    wait_idle();
    if (rx_t.size() == 3) chk("t4_gap", rx_t[2] - rx_t[0], 2 * NB * CPB);
    else chk("t4_frames", rx_t.size(), 3);
    cmp_q("t4_byte");

    // random bytes with random idle gaps
    for (int r = 0; r < 10; r++) begin
      b = 8'($urandom);
      send(b);
      if ($urandom_range(0, 2) != 0) begin
        drop();
        repeat ($urandom_range(1, 60)) @(negedge clk);
      end
    end
    drop();
    wait_idle();
    cmp_q("rnd_byte");

`ifdef USB_UART_TX_PARITY_EN
    // 6: parity bits for 0x07 and 0x03
    send(8'h07);
    send(8'h03);
    drop();
    wait_idle();
    if (rx_t.size() == 2) begin
      chk("t6_frame_len", rx_t[1] - rx_t[0], 44);
      chk("t6_par07", int'(rx_p[0]), 1);
      chk("t6_par03", int'(rx_p[1]), 0);
    end else chk("t6_frames", rx_t.size(), 2);
    cmp_q("t6_byte");
`endif

    // 5: reset mid-DATA of 0xFF with a second byte held
    mon_en = 1'b0;
    send(8'hFF);
    send(8'h81);
    drop();
    repeat (12) @(negedge clk);
    chk("t5_busy_pre", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t5_tx_async", int'(uart_tx), 1);
    chk("t5_rdy_async", int'(bus.uart_out_ready), 1);
    chk("t5_busy_async", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!uart_tx || busy) lows++;
    end
    chk("t5_no_residual", lows, 0);
    chk("t5_rx_empty", rx_q.size(), 0);
    chk("t5_ready", int'(bus.uart_out_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
